// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU sequencer and its program ROM.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned INSTR_W   = 8;
    localparam int unsigned ROM_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_LOAD = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } rom_wr_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled, tick on the last count.
module tick_gen #(
    parameter int unsigned PRESCALE = 2700000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Run/step/halt/load controller for a small CPU and its 16-entry program ROM.
// Define BREAKPOINT_EN to build the pc == bp_addr breakpoint halt.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PRESCALE = 2700000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_halt,
    input  logic               cmd_load,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic               bp_valid,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    output logic               rom_we,
    output logic [ADDR_W-1:0]  rom_waddr,
    output logic [INSTR_W-1:0] rom_wdata,
    output logic               cpu_ce,
    output logic               cpu_rst_n,
    output logic [1:0]         state,
    output logic               bp_hit
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [ADDR_W-1:0] r_wcnt;
    rom_wr_t           r_wr;
    logic              r_rom_we;
    logic              r_load_ready;
    logic              r_cpu_rst_n;
    logic              w_tick;
    logic              w_accept;
    logic              w_bp_stop;
    logic              w_bp_set;
    logic              w_entry;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (r_state != ST_RUN),
        .en    (r_state == ST_RUN),
        .tick  (w_tick)
    );

    assign w_accept = (r_state == ST_LOAD) && load_valid && r_load_ready;
    assign w_entry  = (w_next != r_state) && (w_next != ST_HALT);

    // Next-state logic; command priority is halt > load > step > run.
    always_comb begin
        w_next   = r_state;
        w_bp_set = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (cmd_halt)      w_next = ST_HALT;
                else if (cmd_load) w_next = ST_LOAD;
                else if (cmd_step) w_next = ST_STEP;
                else if (cmd_run)  w_next = ST_RUN;
            end
            ST_RUN: begin
                if (cmd_halt)      w_next = ST_HALT;
                else if (cmd_load) w_next = ST_LOAD;
                else if (w_bp_stop) begin
                    w_next   = ST_HALT;
                    w_bp_set = 1'b1;
                end
            end
            ST_STEP: w_next = ST_HALT;
            ST_LOAD: begin
                if (cmd_halt)                              w_next = ST_HALT;
                else if (w_accept && (r_wcnt == LAST_ADDR)) w_next = ST_HALT;
            end
            default: w_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HALT;
            r_load_ready <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_load_ready <= (w_next == ST_LOAD);
            r_cpu_rst_n  <= (w_next != ST_LOAD);
        end
    end

    // Write counter idles at 0 outside LOAD, so every LOAD entry starts at address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt   <= '0;
            r_rom_we <= 1'b0;
            r_wr     <= '0;
        end else begin
            r_rom_we <= w_accept;
            if (w_accept) begin
                r_wr.addr <= r_wcnt;
                r_wr.data <= load_data;
            end
            if (r_state != ST_LOAD) begin
                r_wcnt <= '0;
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + ADDR_W'(1);
            end
        end
    end

`ifdef BREAKPOINT_EN
    logic r_first_tick;
    logic r_bp_hit;

    // First tick after entering RUN skips the compare so a halted pc can resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_tick <= 1'b0;
        end else if (w_entry && (w_next == ST_RUN)) begin
            r_first_tick <= 1'b1;
        end else if ((r_state == ST_RUN) && w_tick) begin
            r_first_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bp_hit <= 1'b0;
        end else if (w_entry) begin
            r_bp_hit <= 1'b0;
        end else if (w_bp_set) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign w_bp_stop = (r_state == ST_RUN) && w_tick && !r_first_tick
                       && bp_valid && (pc == bp_addr);
    assign bp_hit    = r_bp_hit;
`else
    logic w_unused_bp;

    assign w_bp_stop   = 1'b0;
    assign bp_hit      = 1'b0;
    assign w_unused_bp = &{1'b0, pc, bp_addr, bp_valid, w_bp_set, w_entry};
`endif

    assign cpu_ce     = (r_state == ST_STEP)
                        || ((r_state == ST_RUN) && w_tick && !w_bp_stop);
    assign load_ready = r_load_ready;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign rom_we     = r_rom_we;
    assign rom_waddr  = r_wr.addr;
    assign rom_wdata  = r_wr.data;
    assign state      = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with PRESCALE=4.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_run, cmd_step, cmd_halt, cmd_load;
    logic [3:0] pc;
    logic [3:0] bp_addr;
    logic       bp_valid;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       rom_we;
    logic [3:0] rom_waddr;
    logic [7:0] rom_wdata;
    logic       cpu_ce;
    logic       cpu_rst_n;
    logic [1:0] state;
    logic       bp_hit;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] wlog[$];

    cpu_sequencer #(.PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .cmd_load   (cmd_load),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .cpu_ce     (cpu_ce),
        .cpu_rst_n  (cpu_rst_n),
        .state      (state),
        .bp_hit     (bp_hit)
    );

    always #5 clk = ~clk;

    // Minimal CPU stand-in: pc advances once per cpu_ce, cleared while held in reset.
    always_ff @(posedge clk) begin
        if (!cpu_rst_n) pc <= 4'd0;
        else if (cpu_ce) pc <= pc + 4'd1;
    end

    always @(negedge clk) begin
        if (rom_we === 1'b1) wlog.push_back({rom_waddr, rom_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ce_seen;
        int rst_bad;
        int rdy_bad;

        reset = 1'b1;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cmd_load = 1'b0;
        bp_addr = 4'd0; bp_valid = 1'b0;
        load_valid = 1'b0; load_data = 8'd0;
        cyc(); cyc();

        // Reset values
        chk("rst_state",     32'(state),      32'(0));
        chk("rst_cpu_ce",    32'(cpu_ce),     32'(0));
        chk("rst_rom_we",    32'(rom_we),     32'(0));
        chk("rst_ready",     32'(load_ready), 32'(0));
        chk("rst_cpu_rst_n", 32'(cpu_rst_n),  32'(0));
        chk("rst_bp_hit",    32'(bp_hit),     32'(0));
        reset = 1'b0;
        #1;
        chk("rst_n_still_low", 32'(cpu_rst_n), 32'(0));
        cyc();
        chk("rst_n_release", 32'(cpu_rst_n), 32'(1));

        // RUN: cpu_ce on every 4th cycle after entry
        cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
        chk("run_state", 32'(state), 32'(1));
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("run_ce_%0d", i), 32'(cpu_ce), 32'((i % 4) == 3));
            cyc();
        end
        cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
        chk("run_step_state", 32'(state),  32'(1));
        chk("run_step_ce",    32'(cpu_ce), 32'(1));
        cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
        chk("halt_state", 32'(state), 32'(0));
        ce_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_ce !== 1'b0) ce_seen++;
            cyc();
        end
        chk("halt_no_ce", 32'(ce_seen), 32'(0));

        // STEP: one pulse then back to HALT
        cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
        chk("step_state", 32'(state),  32'(2));
        chk("step_ce",    32'(cpu_ce), 32'(1));
        cyc();
        chk("step_back_state", 32'(state),  32'(0));
        chk("step_back_ce",    32'(cpu_ce), 32'(0));

        // Simultaneous commands
        cmd_run = 1'b1; cmd_halt = 1'b1; cyc(); cmd_run = 1'b0; cmd_halt = 1'b0;
        chk("run_halt_state", 32'(state), 32'(0));
        cmd_load = 1'b1; cmd_step = 1'b1; cyc(); cmd_load = 1'b0; cmd_step = 1'b0;
        chk("load_step_state", 32'(state),      32'(3));
        chk("load_ready",      32'(load_ready), 32'(1));
        chk("load_rst_n",      32'(cpu_rst_n),  32'(0));

        // Full 16-byte load with a gap before every third byte
        wlog.delete();
        rst_bad = 0; rdy_bad = 0;
        for (int n = 0; n < 16; n++) begin
            if ((n % 3) == 2) begin
                load_valid = 1'b0;
                if (cpu_rst_n !== 1'b0) rst_bad++;
                cyc();
            end
            load_valid = 1'b1;
            load_data  = 8'(n);
            if (cpu_rst_n !== 1'b0) rst_bad++;
            if (load_ready !== 1'b1) rdy_bad++;
            cyc();
        end
        chk("load_done_state", 32'(state), 32'(0));
        load_data = 8'hAA;
        cyc();
        load_valid = 1'b0;
        cyc(); cyc();
        chk("load_rst_n_low", 32'(rst_bad), 32'(0));
        chk("load_ready_hi",  32'(rdy_bad), 32'(0));
        chk("load_nwrites",   32'(wlog.size()), 32'(16));
        for (int n = 0; n < 16; n++)
            chk($sformatf("load_wr_%0d", n), 32'(wlog[n]), 32'({4'(n), 8'(n)}));
        chk("post_load_ready", 32'(load_ready), 32'(0));
        chk("post_load_rst_n", 32'(cpu_rst_n),  32'(1));

        // Abort after 5 bytes, then reload restarts at address 0
        wlog.delete();
        cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
        for (int n = 0; n < 5; n++) begin
            load_valid = 1'b1;
            load_data  = 8'(16 + n);
            cyc();
        end
        load_valid = 1'b0;
        cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
        chk("abort_state", 32'(state), 32'(0));
        cyc();
        chk("abort_nwrites", 32'(wlog.size()), 32'(5));
        for (int n = 0; n < 5; n++)
            chk($sformatf("abort_wr_%0d", n), 32'(wlog[n]), 32'({4'(n), 8'(16 + n)}));
        cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
        load_valid = 1'b1; load_data = 8'h55; cyc(); load_valid = 1'b0;
        cyc();
        chk("reload_nwrites", 32'(wlog.size()), 32'(6));
        chk("reload_wr0",     32'(wlog[5]),     32'(12'h055));
        cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;

        // Reset while a write is in flight drops it
        wlog.delete();
        cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
        load_valid = 1'b1; load_data = 8'h77; cyc();
        reset = 1'b1; load_valid = 1'b0;
        #1;
        chk("midload_rst_we",    32'(rom_we),     32'(0));
        chk("midload_rst_state", 32'(state),      32'(0));
        chk("midload_rst_ready", 32'(load_ready), 32'(0));
        chk("midload_rst_rst_n", 32'(cpu_rst_n),  32'(0));
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("midload_nwrites", 32'(wlog.size()), 32'(0));

        // Breakpoint behaviour
        bp_addr = 4'd3; bp_valid = 1'b1;
`ifdef BREAKPOINT_EN
        cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
        for (int k = 0; k < 40 && state !== 2'd0; k++) cyc();
        chk("bp_state",  32'(state),  32'(0));
        chk("bp_pc",     32'(pc),     32'(3));
        chk("bp_hit",    32'(bp_hit), 32'(1));
        cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
        chk("bp_clear", 32'(bp_hit), 32'(0));
        for (int k = 0; k < 10 && cpu_ce !== 1'b1; k++) cyc();
        chk("bp_resume_ce", 32'(cpu_ce), 32'(1));
        cyc();
        chk("bp_resume_pc",    32'(pc),     32'(4));
        chk("bp_resume_state", 32'(state),  32'(1));
        chk("bp_resume_hit",   32'(bp_hit), 32'(0));
`else
        cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        chk("nobp_state", 32'(state),  32'(1));
        chk("nobp_hit",   32'(bp_hit), 32'(0));
        chk("nobp_pc",    32'(pc),     32'(5));
`endif
        cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
        bp_valid = 1'b0;
        chk("final_state", 32'(state), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PRESCALE, default 2700000, sets the number of clk cycles per CPU instruction in RUN (minimum 2).
REQ-002 clk  input  1  system clock; all logic is on the posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_run, cmd_step, cmd_halt, cmd_load  input  1 each  single-cycle command pulses, already debounced.
REQ-005 pc  input  4  CPU program counter (the CPU adr output).
REQ-006 bp_addr  input  4  breakpoint address; bp_valid  input  1  breakpoint armed.
REQ-007 load_valid  input  1 / load_ready  output  1 / load_data  input  8  program byte stream, valid/ready handshake.
REQ-008 rom_we  output  1 / rom_waddr  output  4 / rom_wdata  output  8  program ROM write port.
REQ-009 cpu_ce  output  1  clock enable for the CPU; one pulse equals one instruction.
REQ-010 cpu_rst_n  output  1  active-low reset to the CPU.
REQ-011 state  output  2  current FSM state; bp_hit  output  1  sticky breakpoint flag.

Function
REQ-012 The FSM shall have the states HALT=0, RUN=1, STEP=2 and LOAD=3.
REQ-013 Simultaneous command priority shall be halt > load > step > run; lower-priority commands in the same cycle are ignored.
REQ-014 HALT transitions: cmd_run -> RUN, cmd_step -> STEP, cmd_load -> LOAD; cpu_ce=0.
REQ-015 STEP shall assert cpu_ce for exactly one cycle and then return to HALT unconditionally; breakpoints are ignored.
REQ-016 In RUN, a prescaler counts 0..PRESCALE-1 and cpu_ce=1 only in the cycle the count equals PRESCALE-1; the count then wraps to 0.
REQ-017 The prescaler shall be cleared to 0 on every entry to RUN, so the first cpu_ce occurs PRESCALE cycles after entry.
REQ-018 RUN transitions: cmd_halt -> HALT, cmd_load -> LOAD, cmd_step is ignored; the prescaler is held at 0 outside RUN.
REQ-019 LOAD shall drive load_ready=1 and cpu_rst_n=0; load_ready=0 in all other states.
REQ-020 Each accepted byte (load_valid && load_ready) shall produce rom_we=1 on the next cycle, with rom_wdata equal to the byte and rom_waddr equal to the write counter; the counter then increments.
REQ-021 When the 16th byte is accepted (counter 15 wraps to 0), the FSM shall go to HALT; a byte offered in that same cycle is not accepted.
REQ-022 cmd_halt in LOAD shall abort to HALT, leaving the ROM partially written; the counter resets to 0 and any in-flight rom_we still completes.
REQ-023 Every entry to LOAD shall restart the write counter at 0.
REQ-024 cpu_rst_n shall be 1 in HALT, RUN and STEP, and 0 in LOAD and during reset.
REQ-025 cpu_ce shall be a pure decode of registered state, so it cannot glitch.

Reset
REQ-026 Reset shall force: state=HALT, prescaler=0, write counter=0, bp_hit=0, cpu_ce=0, rom_we=0, load_ready=0, cpu_rst_n=0.
REQ-027 On the first clk edge after reset deasserts, cpu_rst_n shall go to 1.
REQ-028 Reset mid-LOAD or mid-RUN shall abandon the operation with no further rom_we or cpu_ce pulse.

Configuration
REQ-029 With BREAKPOINT_EN defined: in RUN, if bp_valid=1 and pc==bp_addr in a tick cycle, cpu_ce is suppressed, the FSM goes to HALT and bp_hit is set.
REQ-030 With BREAKPOINT_EN defined: the first tick after entering RUN ignores the breakpoint, so execution resumes from the breakpoint address.
REQ-031 With BREAKPOINT_EN defined: bp_hit clears on entry to RUN, STEP or LOAD.
REQ-032 Without BREAKPOINT_EN: bp_addr and bp_valid are unused, bp_hit is tied to 0, and no compare logic is generated.

Structure
REQ-033 A shared package cpu_pkg shall hold the seq_state_t enum, ADDR_W=4, INSTR_W=8 and ROM_DEPTH=16.
REQ-034 The prescaler shall be a sub-module tick_gen (inputs clk, reset, clr, en; output tick).

Verification (PRESCALE=4)
REQ-035 Reset, then cmd_run -> cpu_ce pulses on cycles 4, 8 and 12 after entry; cmd_halt -> no further pulses and state=0.
REQ-036 cmd_step in HALT -> exactly one cpu_ce pulse, then state=0; cmd_step in RUN -> no effect.
REQ-037 cmd_load, then 16 bytes 0x00..0x0F with a valid gap every third byte -> rom_we writes addr n with data n, cpu_rst_n=0 throughout, state=0 after the last byte.
REQ-038 cmd_load, then 5 bytes, then cmd_halt -> addresses 0..4 written, state=0; a second cmd_load restarts writing at address 0.
REQ-039 cmd_run and cmd_halt in the same cycle -> state stays HALT; cmd_load and cmd_step together -> state=LOAD.
REQ-040 BREAKPOINT_EN, bp_addr=3, bp_valid=1, pc advancing -> halt with pc=3 and bp_hit=1; cmd_run -> next tick executes with bp_hit=0.
